// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: fetch-side push and execute-side pop.
// The illegal flag exists only when IMM_GEN_PIPE_ILLEGAL_EN is defined.
interface imm_gen_pipe_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     ins;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm_data;
  logic [2:0]      imm_type;
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
  logic            illegal;

  modport master (
    output in_valid, ins, out_ready,
    input  in_ready, out_valid, imm_data, imm_type, illegal
  );
  modport slave (
    input  in_valid, ins, out_ready,
    output in_ready, out_valid, imm_data, imm_type, illegal
  );
`else
  modport master (
    output in_valid, ins, out_ready,
    input  in_ready, out_valid, imm_data, imm_type
  );
  modport slave (
    input  in_valid, ins, out_ready,
    output in_ready, out_valid, imm_data, imm_type
  );
`endif
endinterface

// File: rtl/imm_gen_pipe.sv
// RV64I immediate generator with a 2-entry skid buffer between fetch and execute.
// Optional per-entry illegal flag is enabled by defining IMM_GEN_PIPE_ILLEGAL_EN.
module imm_gen_pipe #(
  parameter int XLEN     = 64,
  parameter bit SIGN_EXT = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  imm_gen_pipe_if.slave  bus
);

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  function automatic imm_type_e decode_type(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      7'b0000011, 7'b0010011,
      7'b0011011, 7'b1100111: t = IMM_I;
      7'b0100011:             t = IMM_S;
      7'b1100011:             t = IMM_B;
      7'b0110111, 7'b0010111: t = IMM_U;
      7'b1101111:             t = IMM_J;
      default:                t = IMM_NONE;
    endcase
    return t;
  endfunction

  // Built at 64 bits then truncated, so XLEN=32 simply drops the upper word.
  function automatic logic [63:0] build_imm(input logic [31:0] ins, input imm_type_e t);
    logic        e;
    logic [63:0] imm;
    e = SIGN_EXT ? ins[31] : 1'b0;
    case (t)
      IMM_I:   imm = {{52{e}}, ins[31:20]};
      IMM_S:   imm = {{52{e}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{51{e}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {{32{e}}, ins[31:12], 12'b0};
      IMM_J:   imm = {{43{e}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = 64'd0;
    endcase
    return imm;
  endfunction

  function automatic logic is_illegal(input logic [31:0] ins, input imm_type_e t);
    return (t == IMM_NONE) || (ins[1:0] != 2'b11);
  endfunction

  imm_type_e       dec_type_s;
  logic [63:0]     dec_imm64_s;
  logic [XLEN-1:0] dec_imm_s;

  logic [XLEN-1:0] imm_q  [2];
  imm_type_e       type_q [2];
  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;

  logic            in_ready_s;
  logic            out_valid_s;
  logic            push_s;
  logic            pop_s;

  assign dec_type_s  = decode_type(bus.ins[6:0]);
  assign dec_imm64_s = build_imm(bus.ins, dec_type_s);
  assign dec_imm_s   = dec_imm64_s[XLEN-1:0];

  // Reset holds off the producer so nothing is accepted into a buffer being cleared.
  assign in_ready_s  = (count_q != 2'd2) && !reset;
  assign out_valid_s = (count_q != 2'd0);
  assign push_s      = bus.in_valid && in_ready_s;
  assign pop_s       = out_valid_s && bus.out_ready;

  // Next occupancy and pointer values; flush overrides push and pop.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer state and entry storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      imm_q[0]  <= {XLEN{1'b0}};
      imm_q[1]  <= {XLEN{1'b0}};
      type_q[0] <= IMM_NONE;
      type_q[1] <= IMM_NONE;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_s && !flush) begin
        imm_q[wr_ptr_q]  <= dec_imm_s;
        type_q[wr_ptr_q] <= dec_type_s;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.imm_data  = out_valid_s ? imm_q[rd_ptr_q] : {XLEN{1'b0}};
  assign bus.imm_type  = out_valid_s ? type_q[rd_ptr_q] : IMM_NONE;

`ifdef IMM_GEN_PIPE_ILLEGAL_EN
  logic ill_q [2];

  // Illegal flag travels alongside its entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      ill_q[0] <= 1'b0;
      ill_q[1] <= 1'b0;
    end else if (push_s && !flush) begin
      ill_q[wr_ptr_q] <= is_illegal(bus.ins, dec_type_s);
    end
  end

  assign bus.illegal = out_valid_s ? ill_q[rd_ptr_q] : 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed vectors, expected results queued on accept.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  logic clk;
  logic reset;
  logic flush;
  logic aux_valid;
  logic [31:0] aux_ins;

  int checks = 0;
  int errors = 0;

  exp_t cur_exp;
  exp_t sb[$];
  exp_t head;

  imm_gen_pipe_if #(.XLEN(64)) bus   ();
  imm_gen_pipe_if #(.XLEN(64)) bus_z ();
  imm_gen_pipe_if #(.XLEN(32)) bus_n ();

  imm_gen_pipe #(.XLEN(64), .SIGN_EXT(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus.slave)
  );
  imm_gen_pipe #(.XLEN(64), .SIGN_EXT(1'b0)) dut_z (
    .clk(clk), .reset(reset), .flush(1'b0), .bus(bus_z.slave)
  );
  imm_gen_pipe #(.XLEN(32), .SIGN_EXT(1'b1)) dut_n (
    .clk(clk), .reset(reset), .flush(1'b0), .bus(bus_n.slave)
  );

  assign bus_z.in_valid  = aux_valid;
  assign bus_z.ins       = aux_ins;
  assign bus_z.out_ready = 1'b1;
  assign bus_n.in_valid  = aux_valid;
  assign bus_n.ins       = aux_ins;
  assign bus_n.out_ready = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; in_ready is checked against the hand-predicted value.
  task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] imm,
                       input logic [2:0] t, input logic rdy);
    bus.in_valid = v;
    bus.ins      = i;
    cur_exp      = '{imm: imm, typ: t, ill: (t == 3'd0)};
    @(negedge clk);
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare head against the scoreboard, then log this cycle's accept.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
      if (bus.out_valid && sb.size() != 0) begin
        head = sb[0];
        chk("imm_data", bus.imm_data, head.imm);
        chk("imm_type", 64'(bus.imm_type), 64'(head.typ));
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
        chk("illegal", 64'(bus.illegal), 64'(head.ill));
`endif
        if (bus.out_ready) begin
          void'(sb.pop_front());
        end
      end else if (!bus.out_valid) begin
        chk("empty_imm", bus.imm_data, 64'd0);
        chk("empty_type", 64'(bus.imm_type), 64'd0);
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
        chk("empty_illegal", 64'(bus.illegal), 64'd0);
`endif
      end
      if (flush) begin
        sb.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        sb.push_back(cur_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    aux_valid     = 1'b0;
    aux_ins       = 32'd0;
    bus.in_valid  = 1'b0;
    bus.ins       = 32'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 32'd0, 64'd0, 3'd0, 1'b0);
    reset = 1'b0;
    drive(1'b0, 32'd0, 64'd0, 3'd0, 1'b1);

    // Main instance addi -1, plus zero-extend and XLEN=32 variants in parallel.
    aux_valid = 1'b1;
    aux_ins   = 32'hFFF00093;
    drive(1'b1, 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b1);
    aux_ins      = 32'h800000B7;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("z_addi_valid", 64'(bus_z.out_valid), 64'd1);
    chk("z_addi_imm", bus_z.imm_data, 64'h0000_0000_0000_0FFF);
    chk("z_addi_type", 64'(bus_z.imm_type), 64'd1);
    chk("n_addi_imm", 64'(bus_n.imm_data), 64'h0000_0000_FFFF_FFFF);
    @(posedge clk);
    #1;
    aux_valid = 1'b0;
    @(negedge clk);
    chk("z_lui_imm", bus_z.imm_data, 64'h0000_0000_8000_0000);
    chk("n_lui_imm", 64'(bus_n.imm_data), 64'h0000_0000_8000_0000);
    chk("n_lui_type", 64'(bus_n.imm_type), 64'd4);
    @(posedge clk);
    #1;

    // Back-to-back stream, one result per cycle.
    drive(1'b1, 32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b1);
    drive(1'b1, 32'hFE20AC23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b1);
    drive(1'b1, 32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b1);
    drive(1'b1, 32'h0080006F, 64'h0000_0000_0000_0008, 3'd5, 1'b1);
    drive(1'b0, 32'd0, 64'd0, 3'd0, 1'b1);

    // Back-pressure: third instruction is held until a slot frees.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00500113, 64'd5, 3'd1, 1'b1);
    drive(1'b1, 32'h01012083, 64'd16, 3'd1, 1'b1);
    drive(1'b1, 32'h12345037, 64'h0000_0000_1234_5000, 3'd4, 1'b0);
    drive(1'b1, 32'h12345037, 64'h0000_0000_1234_5000, 3'd4, 1'b0);
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h12345037, 64'h0000_0000_1234_5000, 3'd4, 1'b0);
    drive(1'b1, 32'h12345037, 64'h0000_0000_1234_5000, 3'd4, 1'b1);
    drive(1'b0, 32'd0, 64'd0, 3'd0, 1'b1);
    drive(1'b0, 32'd0, 64'd0, 3'd0, 1'b1);

    // Count=1 push+pop, then flush with a pending input.
    drive(1'b1, 32'h00000013, 64'd0, 3'd1, 1'b1);
    drive(1'b1, 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b1);
    flush = 1'b1;
    drive(1'b1, 32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b1);
    flush = 1'b0;
    drive(1'b0, 32'd0, 64'd0, 3'd0, 1'b1);
    drive(1'b0, 32'd0, 64'd0, 3'd0, 1'b1);

    // Reset while full.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00500113, 64'd5, 3'd1, 1'b1);
    drive(1'b1, 32'h0080006F, 64'd8, 3'd5, 1'b1);
    reset = 1'b1;
    drive(1'b0, 32'd0, 64'd0, 3'd0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_imm", bus.imm_data, 64'd0);
    chk("rst_type", 64'(bus.imm_type), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // Unknown opcodes decode to NONE with a zero immediate.
    drive(1'b1, 32'h0000007F, 64'd0, 3'd0, 1'b1);
    drive(1'b1, 32'h00000000, 64'd0, 3'd0, 1'b1);
    drive(1'b1, 32'h01012083, 64'd16, 3'd1, 1'b1);
    drive(1'b0, 32'd0, 64'd0, 3'd0, 1'b1);
    drive(1'b0, 32'd0, 64'd0, 3'd0, 1'b1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered immediate generator for the decode stage.
- Covers all RV64I immediate formats: I, S, B, U and J.
- Accepts one instruction per cycle over a valid/ready handshake and holds results in a 2-entry skid buffer, so back-pressure from execute never drops an instruction.
- Sits between fetch/IF-ID and the ALU operand mux; `imm_data` feeds the ALU B-input and the branch adder.

Parameters:
- XLEN, 64, output immediate width; legal values 32 or 64.
- SIGN_EXT, 1, 1 = sign-extend from instruction bit 31; 0 = zero-extend (legacy mode).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  `ins` is presented.
- in_ready  output  1  buffer can accept this cycle.
- ins  input  32  instruction word.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head.
- imm_data  output  XLEN  immediate of head entry.
- imm_type  output  3  format of head: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.

Behaviour:
- Decode by `ins[6:0]`:
  - 0000011, 0010011, 0011011, 1100111 -> I: `ins[31:20]`.
  - 0100011 -> S: `{ins[31:25], ins[11:7]}`.
  - 1100011 -> B: `{ins[31], ins[7], ins[30:25], ins[11:8], 0}`.
  - 0110111, 0010111 -> U: `{ins[31:12], 12'b0}`.
  - 1101111 -> J: `{ins[31], ins[19:12], ins[20], ins[30:21], 0}`.
  - Any other opcode -> type NONE, `imm_data` = 0.
- Extension to XLEN:
  - SIGN_EXT=1: replicate `ins[31]` into all bits above the field MSB, including U-type when XLEN=64.
  - SIGN_EXT=0: upper bits are zero.
- Storage: 2-entry FIFO of {imm, type}, with occupancy count 0..2, write pointer and read pointer (1 bit each, wrapping).
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - Outputs are driven from the head entry.
- Push when `in_valid & in_ready`; pop when `out_valid & out_ready`.
  - Push only: count+1. Pop only: count-1.
  - Push and pop in the same cycle: count unchanged; both pointers advance.
- Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1 if the buffer was empty; there is no combinational in->out path.
- Full (count=2): in_ready=0 and the input is ignored even if in_valid=1. A pop in that cycle frees a slot for the next cycle, never the same cycle.
- Empty (count=0): out_valid=0; `imm_data`=0 and `imm_type`=0 are forced when empty.
- Flush: count, pointers <= 0 next cycle. A push in the flush cycle is discarded; flush has priority over push and pop.
- Reset (also mid-transfer): count=0, pointers=0, out_valid=0, imm_data=0, imm_type=0, and in_ready=1 from the cycle after reset deasserts. While reset is high in_ready=0.
- `ins`/`in_valid` are sampled only when accepted; stable-while-stalled is not required of the producer.

Optional Feature:
- Macro IMM_GEN_PIPE_ILLEGAL_EN.
- When defined:
  - Extra output port `illegal` (1 bit), stored per entry, high with the head entry when its opcode decoded to NONE or `ins[1:0]` != 2'b11.
  - Reset value 0; forced 0 when empty.
- When undefined: port absent; NONE entries pass silently with `imm_data` 0.

Test Plan:
- Reset, then in_valid=1, ins=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, imm_type=1, imm_data=0xFFFF_FFFF_FFFF_FFFF. With SIGN_EXT=0 -> 0x0000_0000_0000_0FFF.
- Back-to-back stream of four instructions, checked in order:
  - 0xFE000EE3 -> type 3 (B), imm 0xFFFF_FFFF_FFFF_FFFC.
  - 0xFE20AC23 -> type 2 (S), imm 0xFFFF_FFFF_FFFF_FFF8.
  - 0x800000B7 -> type 4 (U), imm 0xFFFF_FFFF_8000_0000.
  - 0x0080006F -> type 5 (J), imm 0x0000_0000_0000_0008.
  - One result per cycle, no bubbles.
- Back-pressure with out_ready=0 while pushing three instructions -> in_ready drops to 0 after two are accepted and the third is held by the producer. Then raise out_ready -> all three emerge in order and the pointer wrap is exercised.
- Count=1 with simultaneous push and pop -> count stays 1 and the new entry appears the next cycle. Then flush with in_valid=1 -> out_valid=0 the next cycle and the flushed-cycle input is never output.
- Assert reset while count=2 -> out_valid=0, imm_data=0, imm_type=0 the next cycle; in_ready=1 after reset deasserts.
- XLEN=32, ins=0x800000B7 -> imm_data=0x8000_0000. With IMM_GEN_PIPE_ILLEGAL_EN defined, ins=0x0000007F -> imm_type=0 with illegal=1.
